// File: rtl/vsc8541_smi_pkg.sv
// vsc8541_smi_pkg: shared types and constants for the VSC8541 SMI sequencer
package vsc8541_smi_pkg;
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
  typedef enum logic [1:0] {SRC_INIT, SRC_POLL, SRC_HOST} src_t;
  typedef struct packed {
    logic [4:0]  reg_addr;
    logic [15:0] data;
  } init_entry_t;
  localparam logic [4:0] BMSR_ADDR = 5'h01;
  localparam int LINK_BIT = 2;
endpackage

// File: rtl/vsc8541_smi_init_rom.sv
// vsc8541_smi_init_rom: combinational PHY init table (idx -> {reg_addr, data}), unused slots read as zero
module vsc8541_smi_init_rom
  import vsc8541_smi_pkg::*;
(
  input  logic [3:0]  idx,
  output init_entry_t entry
);
  always_comb
    entry = idx == 4'd0 ? {5'h00, 16'h8000} :
            idx == 4'd1 ? {5'h1f, 16'h0000} :
            idx == 4'd2 ? {5'h17, 16'h0000} :
            idx == 4'd3 ? {5'h00, 16'h1140} : '0;
endmodule

// File: rtl/vsc8541_smi_seq.sv
// vsc8541_smi_seq: MDIO transaction sequencer - init table writes, periodic BMSR polling, host register access
// clk/i_reset_n: clock, async active-low reset; i_mdc: MDC level used for frame timing
// o_en/o_mode/o_phy_addr/o_reg_addr/o_data: transaction request to MDIO engine; i_dv/i_rdata: engine read result
// i_req*/o_req_done/o_req_rdata: host access handshake; o_init_done/o_link_up/o_err: status
module vsc8541_smi_seq
  import vsc8541_smi_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR    = 5'h05,
  parameter int         N_INIT      = 4,
  parameter int         FRAME_MDC   = 64,
  parameter int         TIMEOUT_MDC = 80,
  parameter int         POLL_MDC    = 1000
) (
  input  logic        clk,
  input  logic        i_reset_n,
  input  logic        i_mdc,
  output logic        o_en,
  output logic        o_mode,
  output logic [4:0]  o_phy_addr,
  output logic [4:0]  o_reg_addr,
  output logic [15:0] o_data,
  input  logic        i_dv,
  input  logic [15:0] i_rdata,
  input  logic        i_req,
  input  logic        i_req_wr,
  input  logic [4:0]  i_req_reg,
  input  logic [15:0] i_req_wdata,
  output logic        o_req_done,
  output logic [15:0] o_req_rdata,
  output logic        o_init_done,
  output logic        o_link_up,
  output logic        o_err
);
  localparam logic [15:0] FRAME_LAST = 16'(FRAME_MDC - 1);
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_MDC - 1);
  localparam logic [15:0] POLL_END   = 16'(POLL_MDC);
  localparam logic [4:0]  INIT_LAST  = 5'(N_INIT - 1);
  state_t      state, state_d;
  src_t        src, src_d;
  init_entry_t entry;
  logic [4:0]  idx, idx_d, reg_d;
  logic [15:0] wcnt, wcnt_d, pcnt, pcnt_d, data_d, rdata_d;
  logic        mdc_q, mdc_rise, in_wait, wr_end, rd_dv, rd_to;
  logic        mode_d, done_d, init_d, link_d, err_d;
  vsc8541_smi_init_rom u_rom (.idx(idx[3:0]), .entry(entry));
  assign mdc_rise   = i_mdc & ~mdc_q;
  assign o_en       = state == ST_ISSUE;
  assign o_phy_addr = PHY_ADDR;
  assign in_wait    = state == ST_WAIT;
  assign wr_end     = in_wait & o_mode & mdc_rise & (wcnt == FRAME_LAST);
  assign rd_dv      = in_wait & ~o_mode & i_dv;
  assign rd_to      = in_wait & ~o_mode & ~i_dv & mdc_rise & (wcnt == TO_LAST);
  always_ff @(posedge clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state       <= ST_INIT;
      src         <= SRC_INIT;
      idx         <= '0;
      mdc_q       <= 1'b0;
      wcnt        <= '0;
      pcnt        <= '0;
      o_mode      <= 1'b0;
      o_reg_addr  <= '0;
      o_data      <= '0;
      o_req_done  <= 1'b0;
      o_req_rdata <= '0;
      o_init_done <= 1'b0;
      o_link_up   <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state       <= state_d;
      src         <= src_d;
      idx         <= idx_d;
      mdc_q       <= i_mdc;
      wcnt        <= wcnt_d;
      pcnt        <= pcnt_d;
      o_mode      <= mode_d;
      o_reg_addr  <= reg_d;
      o_data      <= data_d;
      o_req_done  <= done_d;
      o_req_rdata <= rdata_d;
      o_init_done <= init_d;
      o_link_up   <= link_d;
      o_err       <= err_d;
    end
  always_comb begin
    state_d = state;
    src_d   = src;
    idx_d   = idx;
    wcnt_d  = wcnt;
    pcnt_d  = pcnt;
    mode_d  = o_mode;
    reg_d   = o_reg_addr;
    data_d  = o_data;
    done_d  = 1'b0;
    rdata_d = o_req_rdata;
    init_d  = o_init_done;
    link_d  = o_link_up;
    err_d   = o_err;
    unique case (state)
      ST_INIT: begin
        src_d   = SRC_INIT;
        mode_d  = 1'b1;
        reg_d   = entry.reg_addr;
        data_d  = entry.data;
        state_d = ST_ISSUE;
      end
      ST_IDLE: begin
        if (mdc_rise && pcnt != POLL_END) pcnt_d = pcnt + 16'd1;
        // o_req_done still high means the host has not yet dropped the request it just got answered
        if (i_req && !o_req_done) begin
          src_d   = SRC_HOST;
          mode_d  = i_req_wr;
          reg_d   = i_req_reg;
          data_d  = i_req_wdata;
          state_d = ST_ISSUE;
        end else if (pcnt == POLL_END) begin
          src_d   = SRC_POLL;
          mode_d  = 1'b0;
          reg_d   = BMSR_ADDR;
          data_d  = '0;
          pcnt_d  = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wcnt_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mdc_rise) wcnt_d = wcnt + 16'd1;
        if (wr_end || rd_dv || rd_to) begin
          state_d = ST_IDLE;
          if (src == SRC_INIT) begin
            if (idx == INIT_LAST) init_d = 1'b1;
            else begin
              idx_d   = idx + 5'd1;
              state_d = ST_INIT;
            end
          end
          if (src == SRC_POLL) link_d = rd_dv & i_rdata[LINK_BIT];
          if (src == SRC_HOST) begin
            done_d  = 1'b1;
            rdata_d = rd_dv ? i_rdata : '0;
          end
          if (rd_to) err_d = 1'b1;
        end
      end
    endcase
  end
endmodule

// File: tb/tb_vsc8541_smi_seq.sv
// tb_vsc8541_smi_seq: randomized self-checking bench with a behavioural PHY/MDIO-engine model
module tb_vsc8541_smi_seq;
  localparam int FRAME = 64, TMO = 80, POLL = 1000;
  logic clk = 0, i_reset_n = 0, i_mdc = 0, i_dv = 0, i_req = 0, i_req_wr = 0;
  logic [4:0] i_req_reg = 0;
  logic [15:0] i_req_wdata = 0, i_rdata = 0;
  logic o_en, o_mode, o_req_done, o_init_done, o_link_up, o_err;
  logic [4:0] o_phy_addr, o_reg_addr;
  logic [15:0] o_data, o_req_rdata;
  int checks = 0, errors = 0, rise = 0;
  logic mdc_last = 0;
  bit respond = 1, glitch = 0;
  logic [15:0] phy_regs [32];
  logic [15:0] shadow [32];
  logic [4:0] exp_reg [4] = '{5'h00, 5'h1f, 5'h17, 5'h00};
  logic [15:0] exp_dat [4] = '{16'h8000, 16'h0000, 16'h0000, 16'h1140};

  vsc8541_smi_seq dut (
    .clk(clk), .i_reset_n(i_reset_n), .i_mdc(i_mdc), .o_en(o_en), .o_mode(o_mode),
    .o_phy_addr(o_phy_addr), .o_reg_addr(o_reg_addr), .o_data(o_data), .i_dv(i_dv),
    .i_rdata(i_rdata), .i_req(i_req), .i_req_wr(i_req_wr), .i_req_reg(i_req_reg),
    .i_req_wdata(i_req_wdata), .o_req_done(o_req_done), .o_req_rdata(o_req_rdata),
    .o_init_done(o_init_done), .o_link_up(o_link_up), .o_err(o_err)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    repeat (2) @(posedge clk);
    #1 i_mdc = ~i_mdc;
  end
  always @(negedge clk) begin
    rise = (i_mdc && !mdc_last) ? 1 : 0;
    mdc_last = i_mdc;
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // PHY + MDIO engine model: writes land in phy_regs, reads answer after a random delay
  initial begin : phy
    logic [4:0] r;
    int d;
    forever begin
      @(negedge clk); #2;
      if (o_en && !o_mode && respond) begin
        r = o_reg_addr;
        d = $urandom_range(2, 250);
        repeat (d) @(negedge clk);
        #2 i_rdata = phy_regs[r]; i_dv = 1;
        @(negedge clk);
        #2 i_dv = 0; i_rdata = 16'($urandom);
      end else if (o_en && o_mode) begin
        phy_regs[o_reg_addr] = o_data;
        if (glitch) begin
          repeat (10) @(negedge clk);
          #2 i_dv = 1; i_rdata = 16'hdead;
          @(negedge clk);
          #2 i_dv = 0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic next_en(input bit skip_poll, input int limit, output logic m, output logic [4:0] r,
                         output logic [15:0] d, output int n, output bit ok);
    n = 0; ok = 0; m = 0; r = 0; d = 0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (o_en && !(skip_poll && !o_mode && o_reg_addr == 5'h01)) begin
        m = o_mode; r = o_reg_addr; d = o_data; ok = 1;
        break;
      end
      n += rise;
    end
  endtask

  task automatic wait_done(input int limit, output int n, output bit ok);
    n = 0; ok = 0;
    for (int i = 0; i < limit; i++) begin
      tick();
      n += rise;
      if (o_req_done) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_dv(output bit ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (i_dv) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [62:0] got, exp;
    i_reset_n = 0;
    repeat (3) tick();
    got = {o_en, o_mode, o_phy_addr, o_reg_addr, o_data, o_req_done, o_req_rdata, o_init_done, o_link_up, o_err};
    exp = {1'b0, 1'b0, 5'h05, 5'h00, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_outputs: got %h expected %h", got, exp); end
  endtask

  task automatic test_init();
    logic m; logic [4:0] r; logic [15:0] d, w; int n; bit ok;
    w = 16'($urandom);
    i_req = 1; i_req_wr = 1; i_req_reg = 5'h09; i_req_wdata = w;
    tick();
    i_reset_n = 1;
    for (int k = 0; k < 4; k++) begin
      next_en(0, 2000, m, r, d, n, ok);
      checks++;
      if (!ok || m !== 1'b1 || r !== exp_reg[k] || d !== exp_dat[k] || o_init_done !== 1'b0) begin
        errors++;
        $display("FAIL init_entry[%0d]: got ok=%0d mode=%b reg=%h data=%h done=%b expected mode=1 reg=%h data=%h done=0", k, ok, m, r, d, o_init_done, exp_reg[k], exp_dat[k]);
      end
      if (k > 0) begin
        checks++;
        if (n != FRAME) begin errors++; $display("FAIL init_gap[%0d]: got %0d mdc edges expected %0d", k, n, FRAME); end
      end
    end
    next_en(0, 2000, m, r, d, n, ok);
    checks++;
    if (!ok || m !== 1'b1 || r !== 5'h09 || d !== w || o_init_done !== 1'b1 || n != FRAME) begin
      errors++;
      $display("FAIL held_host_write: got ok=%0d mode=%b reg=%h data=%h init_done=%b gap=%0d expected 1 09 %h 1 %0d", ok, m, r, d, o_init_done, n, w, FRAME);
    end
    shadow[9] = w;
    wait_done(1000, n, ok);
    checks++;
    if (!ok || n != FRAME || o_req_rdata !== 16'h0) begin
      errors++; $display("FAIL held_host_done: got ok=%0d edges=%0d rdata=%h expected edges=%0d rdata=0000", ok, n, o_req_rdata, FRAME);
    end
    i_req = 0;
  endtask

  task automatic test_host_read();
    logic m; logic [4:0] r; logic [15:0] d; int n; bit ok;
    phy_regs[5'h1b] = 16'h5aa5; shadow[5'h1b] = 16'h5aa5;
    i_req = 1; i_req_wr = 0; i_req_reg = 5'h1b;
    next_en(1, 6000, m, r, d, n, ok);
    checks++;
    if (!ok || m !== 1'b0 || r !== 5'h1b || o_phy_addr !== 5'h05) begin
      errors++; $display("FAIL host_read_issue: got ok=%0d mode=%b reg=%h phy=%h expected mode=0 reg=1b phy=05", ok, m, r, o_phy_addr);
    end
    wait_done(1000, n, ok);
    checks++;
    if (!ok || o_req_rdata !== 16'h5aa5) begin errors++; $display("FAIL host_read_data: got ok=%0d rdata=%h expected 5aa5", ok, o_req_rdata); end
    i_req = 0;
    tick();
    checks++;
    if (o_req_done !== 1'b0) begin errors++; $display("FAIL host_read_pulse: got done=%b expected 0", o_req_done); end
  endtask

  task automatic test_host_write();
    logic m; logic [4:0] r; logic [15:0] d; int n; bit ok;
    glitch = 1;
    i_req = 1; i_req_wr = 1; i_req_reg = 5'h1b; i_req_wdata = 16'ha55a;
    next_en(1, 6000, m, r, d, n, ok);
    checks++;
    if (!ok || m !== 1'b1 || r !== 5'h1b || d !== 16'ha55a) begin
      errors++; $display("FAIL host_write_issue: got ok=%0d mode=%b reg=%h data=%h expected 1 1b a55a", ok, m, r, d);
    end
    wait_done(1000, n, ok);
    checks++;
    if (!ok || n != FRAME || o_req_rdata !== 16'h0) begin
      errors++; $display("FAIL host_write_done: got ok=%0d edges=%0d rdata=%h expected edges=%0d rdata=0000", ok, n, o_req_rdata, FRAME);
    end
    shadow[5'h1b] = 16'ha55a;
    glitch = 0;
    i_req = 0;
    tick();
  endtask

  task automatic test_poll();
    logic m; logic [4:0] r; logic [15:0] d; int n; bit ok;
    logic [15:0] vals [4];
    vals[0] = 16'h7869; vals[1] = 16'h7849; vals[2] = 16'($urandom); vals[3] = 16'($urandom) | 16'h0004;
    i_dv = 1; i_rdata = 16'hffff;
    tick();
    i_dv = 0;
    tick();
    checks++;
    if (o_link_up !== 1'b0 || o_req_done !== 1'b0) begin
      errors++; $display("FAIL idle_dv_ignored: got link=%b done=%b expected 0 0", o_link_up, o_req_done);
    end
    for (int k = 0; k < 4; k++) begin
      phy_regs[1] = vals[k];
      next_en(0, 6000, m, r, d, n, ok);
      checks++;
      if (!ok || m !== 1'b0 || r !== 5'h01) begin errors++; $display("FAIL poll_issue[%0d]: got ok=%0d mode=%b reg=%h expected 0 01", k, ok, m, r); end
      wait_dv(ok);
      checks++;
      if (!ok || o_link_up !== vals[k][2] || o_err !== 1'b0) begin
        errors++; $display("FAIL poll_link[%0d]: got ok=%0d link=%b err=%b expected link=%b err=0", k, ok, o_link_up, o_err, vals[k][2]);
      end
    end
  endtask

  task automatic test_timeout();
    logic m; logic [4:0] r; logic [15:0] d; int n; bit ok;
    respond = 0;
    next_en(0, 6000, m, r, d, n, ok);
    checks++;
    if (!ok || m !== 1'b0 || r !== 5'h01) begin errors++; $display("FAIL timeout_issue: got ok=%0d mode=%b reg=%h expected 0 01", ok, m, r); end
    n = 0; ok = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      n += rise;
      if (o_err) begin ok = 1; break; end
    end
    checks++;
    if (!ok || n != TMO || o_link_up !== 1'b0) begin
      errors++; $display("FAIL timeout_exit: got ok=%0d edges=%0d link=%b expected edges=%0d link=0", ok, n, o_link_up, TMO);
    end
    respond = 1;
  endtask

  task automatic test_back_to_back();
    logic m; logic [4:0] r, rr; logic [15:0] d, wd, exp; logic wr; int n; bit ok;
    for (int k = 0; k < 8; k++) begin
      rr = 5'($urandom_range(2, 16)); wr = 1'($urandom_range(0, 1)); wd = 16'($urandom);
      i_req = 1; i_req_wr = wr; i_req_reg = rr; i_req_wdata = wd;
      next_en(1, 6000, m, r, d, n, ok);
      checks++;
      if (!ok || m !== wr || r !== rr || (wr && d !== wd)) begin
        errors++; $display("FAIL b2b_issue[%0d]: got ok=%0d mode=%b reg=%h data=%h expected %b %h %h", k, ok, m, r, d, wr, rr, wd);
      end
      exp = wr ? 16'h0 : shadow[rr];
      wait_done(1000, n, ok);
      checks++;
      if (!ok || o_req_rdata !== exp) begin errors++; $display("FAIL b2b_done[%0d]: got ok=%0d rdata=%h expected %h", k, ok, o_req_rdata, exp); end
      if (wr) shadow[rr] = wd;
    end
    i_req = 0;
    tick();
  endtask

  task automatic test_priority();
    logic m; logic [4:0] r, rr; logic [15:0] d; int n; bit ok;
    next_en(0, 6000, m, r, d, n, ok);
    checks++;
    if (!ok || r !== 5'h01) begin errors++; $display("FAIL prio_first_poll: got ok=%0d reg=%h expected 01", ok, r); end
    wait_dv(ok);
    n = rise;
    for (int i = 0; i < 6000 && n < POLL; i++) begin
      tick();
      n += rise;
    end
    checks++;
    if (!ok || n != POLL) begin errors++; $display("FAIL prio_sync: got ok=%0d edges=%0d expected %0d", ok, n, POLL); end
    tick();
    checks++;
    if (o_en !== 1'b0) begin errors++; $display("FAIL prio_early_poll: got en=%b expected 0", o_en); end
    rr = 5'($urandom_range(2, 16));
    i_req = 1; i_req_wr = 0; i_req_reg = rr;
    next_en(0, 4, m, r, d, n, ok);
    checks++;
    if (!ok || m !== 1'b0 || r !== rr) begin errors++; $display("FAIL prio_host_wins: got ok=%0d mode=%b reg=%h expected 0 %h", ok, m, r, rr); end
    wait_done(1000, n, ok);
    checks++;
    if (!ok || o_req_rdata !== shadow[rr]) begin errors++; $display("FAIL prio_host_data: got ok=%0d rdata=%h expected %h", ok, o_req_rdata, shadow[rr]); end
    i_req = 0;
    tick();
    checks++;
    if (o_en !== 1'b1 || o_reg_addr !== 5'h01 || o_mode !== 1'b0 || o_req_done !== 1'b0) begin
      errors++; $display("FAIL prio_poll_next: got en=%b reg=%h mode=%b done=%b expected 1 01 0 0", o_en, o_reg_addr, o_mode, o_req_done);
    end
  endtask

  task automatic test_reset_mid();
    logic m; logic [4:0] r; logic [15:0] d; int n; bit ok;
    logic [62:0] got, exp;
    exp = {1'b0, 1'b0, 5'h05, 5'h00, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (o_err !== 1'b1 || o_init_done !== 1'b1) begin errors++; $display("FAIL sticky_flags: got err=%b init_done=%b expected 1 1", o_err, o_init_done); end
    #2 i_reset_n = 0;
    #1 got = {o_en, o_mode, o_phy_addr, o_reg_addr, o_data, o_req_done, o_req_rdata, o_init_done, o_link_up, o_err};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL async_reset: got %h expected %h", got, exp); end
    repeat (2) tick();
    i_reset_n = 1;
    for (int k = 0; k < 3; k++) next_en(0, 2000, m, r, d, n, ok);
    checks++;
    if (!ok || r !== 5'h17) begin errors++; $display("FAIL mid_entry2: got ok=%0d reg=%h expected 17", ok, r); end
    repeat (20) tick();
    #2 i_reset_n = 0;
    #1 got = {o_en, o_mode, o_phy_addr, o_reg_addr, o_data, o_req_done, o_req_rdata, o_init_done, o_link_up, o_err};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL mid_reset_outputs: got %h expected %h", got, exp); end
    repeat (3) tick();
    i_reset_n = 1;
    next_en(0, 2000, m, r, d, n, ok);
    checks++;
    if (!ok || m !== 1'b1 || r !== 5'h00 || d !== 16'h8000) begin
      errors++; $display("FAIL init_restart: got ok=%0d mode=%b reg=%h data=%h expected 1 00 8000", ok, m, r, d);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      phy_regs[i] = 16'($urandom);
      shadow[i] = phy_regs[i];
    end
    test_reset();
    test_init();
    test_host_read();
    test_host_write();
    test_poll();
    test_timeout();
    test_back_to_back();
    test_priority();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
